ibex_rf_wb_arbiter: RTL and testbench



---
 rtl/ibex_rf_arb_pkg.sv | 22 ++
 rtl/ibex_rf_wb_arbiter_if.sv | 27 ++
 rtl/ibex_rf_arb_grant.sv | 32 +++
 rtl/ibex_rf_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states, write request
// record and starve counter width.
package ibex_rf_arb_pkg;

    typedef enum logic {
        ARB_INIT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_e;

    // Default RV32 register-file geometry (32 x 32-bit)
    localparam int unsigned RfAddrW = 5;
    localparam int unsigned RfDataW = 32;

    typedef struct packed {
        logic [RfAddrW-1:0] addr;
        logic [RfDataW-1:0] wdata;
    } rf_wr_req_t;

    // Wide enough for StarveLimit values up to 15
    localparam int unsigned StarveCntW = 4;

endpackage

// File: rtl/ibex_rf_wb_arbiter_if.sv
// Writeback request bundle for the two requesters (load/store = req0, execute = req1).
// Signal names follow the arbiter's point of view.
interface ibex_rf_wb_arbiter_if #(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned DataWidth = 32
);
    logic                 req0_valid_i;
    logic [AddrWidth-1:0] req0_addr_i;
    logic [DataWidth-1:0] req0_wdata_i;
    logic                 req0_ready_o;
    logic                 req1_valid_i;
    logic [AddrWidth-1:0] req1_addr_i;
    logic [DataWidth-1:0] req1_wdata_i;
    logic                 req1_ready_o;

    modport master (
        output req0_valid_i, req0_addr_i, req0_wdata_i,
        output req1_valid_i, req1_addr_i, req1_wdata_i,
        input  req0_ready_o, req1_ready_o
    );

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_wdata_i,
        input  req1_valid_i, req1_addr_i, req1_wdata_i,
        output req0_ready_o, req1_ready_o
    );
endinterface

// File: rtl/ibex_rf_arb_grant.sv
// Combinational two-way grant. Default: req0 over req1 with starvation promotion.
// IBEX_RF_ARB_RR_EN: round-robin driven by a last-grant pointer.
module ibex_rf_arb_grant
    import ibex_rf_arb_pkg::*;
#(
    parameter int unsigned StarveLimit = 4
) (
    input  logic                  valid0_i,
    input  logic                  valid1_i,
`ifdef IBEX_RF_ARB_RR_EN
    input  logic                  last_gnt_i,
`else
    input  logic [StarveCntW-1:0] starve_cnt_i,
`endif
    output logic                  gnt0_o,
    output logic                  gnt1_o
);

    logic prio1;

    always_comb begin
`ifdef IBEX_RF_ARB_RR_EN
        // req0 served last, so req1 goes first this time
        prio1 = ~last_gnt_i;
`else
        prio1 = (starve_cnt_i == StarveCntW'(StarveLimit));
`endif
        gnt1_o = valid1_i & (prio1 | ~valid0_i);
        gnt0_o = valid0_i & ~gnt1_o;
    end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Write-port controller for the flop register file: init sweep, then 2-way writeback
// arbitration with a registered write. Optional round-robin under IBEX_RF_ARB_RR_EN.
module ibex_rf_wb_arbiter
    import ibex_rf_arb_pkg::*;
#(
    parameter int unsigned          NumRegs     = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] InitVal     = '0,
    parameter int unsigned          StarveLimit = 4,
    localparam int unsigned         AddrWidth   = $clog2(NumRegs)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ibex_rf_wb_arbiter_if.slave   wb,
    output logic [AddrWidth-1:0]  rf_waddr_o,
    output logic [DataWidth-1:0]  rf_wdata_o,
    output logic                  rf_we_o,
    output logic                  init_done_o,
    output logic                  collision_o
);

    arb_state_e           state_q, state_d;
    logic [AddrWidth-1:0] init_cnt_q, init_cnt_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 init_done_q, init_done_d;
    logic                 collision_q, collision_d;

    logic                 run;
    logic                 v0, v1;
    logic                 gnt0, gnt1;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;

    assign run = (state_q == ARB_RUN);
    assign v0  = run & wb.req0_valid_i;
    assign v1  = run & wb.req1_valid_i;

`ifdef IBEX_RF_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    ibex_rf_arb_grant #(.StarveLimit(StarveLimit)) u_grant (
        .valid0_i   (v0),
        .valid1_i   (v1),
        .last_gnt_i (last_gnt_q),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1)
    );

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;

    ibex_rf_arb_grant #(.StarveLimit(StarveLimit)) u_grant (
        .valid0_i     (v0),
        .valid1_i     (v1),
        .starve_cnt_i (starve_cnt_q),
        .gnt0_o       (gnt0),
        .gnt1_o       (gnt1)
    );

    // Counts consecutive denied cycles of req1, saturating at the promotion point
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!v1 || gnt1) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != StarveCntW'(StarveLimit)) begin
            starve_cnt_d = starve_cnt_q + StarveCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign wb.req0_ready_o = gnt0;
    assign wb.req1_ready_o = gnt1;

    assign sel_addr  = gnt0 ? wb.req0_addr_i  : wb.req1_addr_i;
    assign sel_wdata = gnt0 ? wb.req0_wdata_i : wb.req1_wdata_i;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        collision_d = 1'b0;

        unique case (state_q)
            ARB_INIT: begin
                we_d    = 1'b1;
                waddr_d = init_cnt_q;
                wdata_d = InitVal;
                if (init_cnt_q == AddrWidth'(NumRegs - 1)) begin
                    state_d = ARB_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + AddrWidth'(1);
                end
            end
            ARB_RUN: begin
                // x0 is hardwired: the request is acknowledged but never written
                if ((gnt0 || gnt1) && (sel_addr != '0)) begin
                    we_d    = 1'b1;
                    waddr_d = sel_addr;
                    wdata_d = sel_wdata;
                end
                collision_d = v0 && v1 && (wb.req0_addr_i == wb.req1_addr_i) &&
                              (wb.req0_addr_i != '0);
            end
            default: state_d = ARB_INIT;
        endcase

        init_done_d = (state_d == ARB_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_INIT;
            init_cnt_q  <= AddrWidth'(1);
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
            collision_q <= collision_d;
        end
    end

    assign rf_we_o     = we_q;
    assign rf_waddr_o  = waddr_q;
    assign rf_wdata_o  = wdata_q;
    assign init_done_o = init_done_q;
    assign collision_o = collision_q;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for ibex_rf_wb_arbiter (NumRegs=32, StarveLimit=4); the round-robin
// scenario replaces the starvation scenario when IBEX_RF_ARB_RR_EN is defined.
module tb_ibex_rf_wb_arbiter;
    import ibex_rf_arb_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_we_o;
    logic        init_done_o;
    logic        collision_o;

    int n_cmp = 0;
    int n_bad = 0;

    ibex_rf_wb_arbiter_if #(.AddrWidth(5), .DataWidth(32)) wb_if ();

    ibex_rf_wb_arbiter #(
        .NumRegs     (32),
        .DataWidth   (32),
        .InitVal     (32'h0),
        .StarveLimit (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wb          (wb_if.slave),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_we_o     (rf_we_o),
        .init_done_o (init_done_o),
        .collision_o (collision_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_req(input int idx, input logic v, input rf_wr_req_t r);
        if (idx == 0) begin
            wb_if.req0_valid_i = v;
            wb_if.req0_addr_i  = r.addr;
            wb_if.req0_wdata_i = r.wdata;
        end else begin
            wb_if.req1_valid_i = v;
            wb_if.req1_addr_i  = r.addr;
            wb_if.req1_wdata_i = r.wdata;
        end
    endtask

    task automatic test_reset();
        rf_wr_req_t r;
        r = '{addr: 5'd3, wdata: 32'h0000_0033};
        rst_ni = 1'b0;
        set_req(0, 1'b0, r);
        set_req(1, 1'b0, r);
        tick();
        tick();
        set_req(0, 1'b1, r);
        #1;
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got %0h want 0", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd0) begin n_bad++; $display("FAIL reset_waddr got %0h want 0", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got %0h want 0", rf_wdata_o); end
        n_cmp++; if (init_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_init_done got %0h want 0", init_done_o); end
        n_cmp++; if (collision_o !== 1'b0) begin n_bad++; $display("FAIL reset_collision got %0h want 0", collision_o); end
        n_cmp++; if (wb_if.req0_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready0 got %0h want 0", wb_if.req0_ready_o); end
        n_cmp++; if (wb_if.req1_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready1 got %0h want 0", wb_if.req1_ready_o); end
    endtask

    // req0 stays valid through INIT and must never be granted
    task automatic test_init_sweep();
        rst_ni = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            n_cmp++; if (rf_we_o !== 1'b1) begin n_bad++; $display("FAIL sweep_we[%0d] got %0h want 1", k, rf_we_o); end
            n_cmp++; if (rf_waddr_o !== 5'(k)) begin n_bad++; $display("FAIL sweep_waddr[%0d] got %0d want %0d", k, rf_waddr_o, k); end
            n_cmp++; if (rf_wdata_o !== 32'd0) begin n_bad++; $display("FAIL sweep_wdata[%0d] got %0h want 0", k, rf_wdata_o); end
            n_cmp++; if (init_done_o !== (k == 31)) begin n_bad++; $display("FAIL sweep_init_done[%0d] got %0h want %0h", k, init_done_o, (k == 31)); end
            if (k < 31) begin
                n_cmp++; if (wb_if.req0_ready_o !== 1'b0) begin n_bad++; $display("FAIL sweep_ready0[%0d] got %0h want 0", k, wb_if.req0_ready_o); end
            end
            if (k == 30) wb_if.req0_valid_i = 1'b0;
        end
        tick();
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL post_sweep_we got %0h want 0", rf_we_o); end
        n_cmp++; if (init_done_o !== 1'b1) begin n_bad++; $display("FAIL post_sweep_init_done got %0h want 1", init_done_o); end
    endtask

    task automatic test_priority();
        set_req(0, 1'b1, '{addr: 5'd5, wdata: 32'hDEAD_BEEF});
        set_req(1, 1'b1, '{addr: 5'd7, wdata: 32'h0000_1234});
        #1;
        n_cmp++; if (wb_if.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL prio_ready0 got %0h want 1", wb_if.req0_ready_o); end
        n_cmp++; if (wb_if.req1_ready_o !== 1'b0) begin n_bad++; $display("FAIL prio_ready1 got %0h want 0", wb_if.req1_ready_o); end
        tick();
        wb_if.req0_valid_i = 1'b0;
        #1;
        n_cmp++; if (rf_we_o !== 1'b1) begin n_bad++; $display("FAIL prio_we_n1 got %0h want 1", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd5) begin n_bad++; $display("FAIL prio_waddr_n1 got %0d want 5", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL prio_wdata_n1 got %0h want deadbeef", rf_wdata_o); end
        n_cmp++; if (collision_o !== 1'b0) begin n_bad++; $display("FAIL prio_collision got %0h want 0", collision_o); end
        n_cmp++; if (wb_if.req1_ready_o !== 1'b1) begin n_bad++; $display("FAIL prio_ready1_n1 got %0h want 1", wb_if.req1_ready_o); end
        tick();
        wb_if.req1_valid_i = 1'b0;
        #1;
        n_cmp++; if (rf_we_o !== 1'b1) begin n_bad++; $display("FAIL prio_we_n2 got %0h want 1", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd7) begin n_bad++; $display("FAIL prio_waddr_n2 got %0d want 7", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== 32'h0000_1234) begin n_bad++; $display("FAIL prio_wdata_n2 got %0h want 1234", rf_wdata_o); end
        tick();
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL idle_we got %0h want 0", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd7) begin n_bad++; $display("FAIL idle_waddr_hold got %0d want 7", rf_waddr_o); end
    endtask

`ifndef IBEX_RF_ARB_RR_EN
    // req1 denied four cycles, promoted on the fifth, then req0 resumes
    task automatic test_starvation();
        set_req(0, 1'b1, '{addr: 5'd2, wdata: 32'h0000_00A0});
        set_req(1, 1'b1, '{addr: 5'd3, wdata: 32'h0000_00B0});
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_cmp++; if (wb_if.req1_ready_o !== (c == 5)) begin n_bad++; $display("FAIL starve_ready1[%0d] got %0h want %0h", c, wb_if.req1_ready_o, (c == 5)); end
            n_cmp++; if (wb_if.req0_ready_o !== (c != 5)) begin n_bad++; $display("FAIL starve_ready0[%0d] got %0h want %0h", c, wb_if.req0_ready_o, (c != 5)); end
            tick();
            n_cmp++; if (rf_waddr_o !== ((c == 5) ? 5'd3 : 5'd2)) begin n_bad++; $display("FAIL starve_waddr[%0d] got %0d want %0d", c, rf_waddr_o, (c == 5) ? 3 : 2); end
            if (c == 5) wb_if.req1_valid_i = 1'b0;
        end
        #1;
        n_cmp++; if (wb_if.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL starve_resume_ready0 got %0h want 1", wb_if.req0_ready_o); end
        tick();
        wb_if.req0_valid_i = 1'b0;
        n_cmp++; if (rf_wdata_o !== 32'h0000_00A0) begin n_bad++; $display("FAIL starve_resume_wdata got %0h want a0", rf_wdata_o); end
        tick();
    endtask
`endif

    task automatic test_collision();
        set_req(0, 1'b1, '{addr: 5'd9, wdata: 32'h0000_1111});
        set_req(1, 1'b1, '{addr: 5'd9, wdata: 32'h0000_2222});
        #1;
        n_cmp++; if (wb_if.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL coll_ready0 got %0h want 1", wb_if.req0_ready_o); end
        n_cmp++; if (collision_o !== 1'b0) begin n_bad++; $display("FAIL coll_early got %0h want 0", collision_o); end
        tick();
        wb_if.req0_valid_i = 1'b0;
        #1;
        n_cmp++; if (collision_o !== 1'b1) begin n_bad++; $display("FAIL coll_pulse got %0h want 1", collision_o); end
        n_cmp++; if (rf_wdata_o !== 32'h0000_1111) begin n_bad++; $display("FAIL coll_first_wdata got %0h want 1111", rf_wdata_o); end
        n_cmp++; if (wb_if.req1_ready_o !== 1'b1) begin n_bad++; $display("FAIL coll_ready1 got %0h want 1", wb_if.req1_ready_o); end
        tick();
        wb_if.req1_valid_i = 1'b0;
        n_cmp++; if (collision_o !== 1'b0) begin n_bad++; $display("FAIL coll_single got %0h want 0", collision_o); end
        n_cmp++; if (rf_waddr_o !== 5'd9) begin n_bad++; $display("FAIL coll_second_waddr got %0d want 9", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== 32'h0000_2222) begin n_bad++; $display("FAIL coll_second_wdata got %0h want 2222", rf_wdata_o); end
        tick();
    endtask

    task automatic test_addr_zero();
        set_req(1, 1'b1, '{addr: 5'd0, wdata: 32'h0000_FFFF});
        #1;
        n_cmp++; if (wb_if.req1_ready_o !== 1'b1) begin n_bad++; $display("FAIL x0_ready1 got %0h want 1", wb_if.req1_ready_o); end
        tick();
        wb_if.req1_valid_i = 1'b0;
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL x0_we got %0h want 0", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd9) begin n_bad++; $display("FAIL x0_waddr_hold got %0d want 9", rf_waddr_o); end
        tick();
    endtask

    // A write accepted just before reset must never reach the port
    task automatic test_reset_mid_run();
        set_req(0, 1'b1, '{addr: 5'd4, wdata: 32'h0000_0044});
        #1;
        n_cmp++; if (wb_if.req0_ready_o !== 1'b1) begin n_bad++; $display("FAIL rrun_ready0 got %0h want 1", wb_if.req0_ready_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (init_done_o !== 1'b0) begin n_bad++; $display("FAIL rrun_init_done got %0h want 0", init_done_o); end
        n_cmp++; if (wb_if.req0_ready_o !== 1'b0) begin n_bad++; $display("FAIL rrun_ready0_rst got %0h want 0", wb_if.req0_ready_o); end
        tick();
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rrun_we got %0h want 0", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd0) begin n_bad++; $display("FAIL rrun_waddr got %0d want 0", rf_waddr_o); end
        wb_if.req0_valid_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (rf_we_o !== 1'b1) begin n_bad++; $display("FAIL rrun_restart_we got %0h want 1", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd1) begin n_bad++; $display("FAIL rrun_restart_waddr got %0d want 1", rf_waddr_o); end
    endtask

    // Continues the sweep restarted above, resets at addr 12, then runs to completion
    task automatic test_reset_mid_init();
        int n;
        for (int k = 2; k <= 12; k++) tick();
        n_cmp++; if (rf_waddr_o !== 5'd12) begin n_bad++; $display("FAIL rinit_at12 got %0d want 12", rf_waddr_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rinit_we got %0h want 0", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd0) begin n_bad++; $display("FAIL rinit_waddr got %0d want 0", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== 32'd0) begin n_bad++; $display("FAIL rinit_wdata got %0h want 0", rf_wdata_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (rf_waddr_o !== 5'd1) begin n_bad++; $display("FAIL rinit_restart got %0d want 1", rf_waddr_o); end
        n = 0;
        while (init_done_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 30) begin n_bad++; $display("FAIL rinit_sweep_len got %0d want 30", n); end
        n_cmp++; if (rf_waddr_o !== 5'd31) begin n_bad++; $display("FAIL rinit_last_addr got %0d want 31", rf_waddr_o); end
        tick();
    endtask

`ifdef IBEX_RF_ARB_RR_EN
    task automatic test_round_robin();
        set_req(0, 1'b1, '{addr: 5'd10, wdata: 32'h0000_00AA});
        set_req(1, 1'b1, '{addr: 5'd11, wdata: 32'h0000_00BB});
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (wb_if.req0_ready_o !== (i % 2 == 0)) begin n_bad++; $display("FAIL rr_ready0[%0d] got %0h want %0h", i, wb_if.req0_ready_o, (i % 2 == 0)); end
            n_cmp++; if (wb_if.req1_ready_o !== (i % 2 == 1)) begin n_bad++; $display("FAIL rr_ready1[%0d] got %0h want %0h", i, wb_if.req1_ready_o, (i % 2 == 1)); end
            tick();
            n_cmp++; if (rf_waddr_o !== ((i % 2 == 0) ? 5'd10 : 5'd11)) begin n_bad++; $display("FAIL rr_waddr[%0d] got %0d want %0d", i, rf_waddr_o, (i % 2 == 0) ? 10 : 11); end
        end
        wb_if.req0_valid_i = 1'b0;
        wb_if.req1_valid_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_init_sweep();
        test_priority();
`ifndef IBEX_RF_ARB_RR_EN
        test_starvation();
`endif
        test_collision();
        test_addr_zero();
        test_reset_mid_run();
        test_reset_mid_init();
`ifdef IBEX_RF_ARB_RR_EN
        test_round_robin();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
